// File: rtl/normalizador_deslocamento.sv
// Iterative 64-bit normalizer: finds the left shift N that normalizes a value
// (unsigned: MSB set; signed: bit63 != bit62) using coarse 8-bit and fine 1-bit steps.
module normalizador_deslocamento #(
  parameter int LARGURA      = 64,
  parameter int PASSO_GROSSO = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               Iniciar,
  input  logic               Sinal,
  input  logic [LARGURA-1:0] Entrada,
  output logic [LARGURA-1:0] Saida,
  output logic [5:0]         N,
  output logic               Zero,
  output logic               Ocupado,
  output logic               Pronto
);

  // A coarse step is only allowed while the count can still absorb a full step.
  localparam logic [5:0] C_MAX_GROSSO = 6'(LARGURA - 1 - PASSO_GROSSO);
  localparam logic [5:0] C_PASSO      = 6'(PASSO_GROSSO);

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    NORMALIZA = 2'b01,
    FIM       = 2'b10
  } estado_t;

  estado_t                estado_r;
  logic [LARGURA-1:0]     r_r;
  logic [LARGURA-1:0]     saida_r;
  logic                   sinal_r;
  logic [5:0]             c_r;
  logic [5:0]             n_r;
  logic                   zero_r;
  logic                   ocupado_r;
  logic                   pronto_r;

  logic                   degenerado_s;
  logic                   normalizado_s;
  logic                   grosso_s;
  logic [PASSO_GROSSO:0]  topo_s;

  // Step decision: degenerate operand, normalized test and coarse-step eligibility.
  always_comb begin
    degenerado_s = (Entrada == {LARGURA{1'b0}}) ||
                   (Sinal && (Entrada == {LARGURA{1'b1}}));
    topo_s       = r_r[LARGURA-1 -: PASSO_GROSSO+1];
    if (sinal_r) begin
      normalizado_s = r_r[LARGURA-1] ^ r_r[LARGURA-2];
      grosso_s      = (topo_s == {(PASSO_GROSSO+1){1'b0}}) ||
                      (topo_s == {(PASSO_GROSSO+1){1'b1}});
    end else begin
      normalizado_s = r_r[LARGURA-1];
      grosso_s      = (topo_s[PASSO_GROSSO:1] == {PASSO_GROSSO{1'b0}});
    end
    grosso_s = grosso_s && (c_r <= C_MAX_GROSSO);
  end

  // Control FSM with working register, count and registered results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado_r  <= OCIOSO;
      r_r       <= {LARGURA{1'b0}};
      sinal_r   <= 1'b0;
      c_r       <= 6'd0;
      saida_r   <= {LARGURA{1'b0}};
      n_r       <= 6'd0;
      zero_r    <= 1'b0;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          pronto_r <= 1'b0;
          if (Iniciar) begin
            r_r       <= Entrada;
            sinal_r   <= Sinal;
            c_r       <= 6'd0;
            ocupado_r <= 1'b1;
            if (degenerado_s) begin
              saida_r  <= Entrada;
              n_r      <= 6'd0;
              zero_r   <= 1'b1;
              pronto_r <= 1'b1;
              estado_r <= FIM;
            end else begin
              zero_r   <= 1'b0;
              estado_r <= NORMALIZA;
            end
          end else begin
            ocupado_r <= 1'b0;
          end
        end
        NORMALIZA: begin
          if (normalizado_s) begin
            saida_r  <= r_r;
            n_r      <= c_r;
            pronto_r <= 1'b1;
            estado_r <= FIM;
          end else if (grosso_s) begin
            r_r <= r_r << PASSO_GROSSO;
            c_r <= c_r + C_PASSO;
          end else begin
            r_r <= r_r << 1;
            c_r <= c_r + 6'd1;
          end
        end
        FIM: begin
          // Iniciar is not looked at here, so back-to-back ops get one idle cycle.
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          estado_r  <= OCIOSO;
        end
        default: begin
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          estado_r  <= OCIOSO;
        end
      endcase
    end
  end

  assign Saida   = saida_r;
  assign N       = n_r;
  assign Zero    = zero_r;
  assign Ocupado = ocupado_r;
  assign Pronto  = pronto_r;

endmodule

// File: tb/tb_normalizador_deslocamento.sv
// Bench for normalizador_deslocamento: directed operations against literal
// expectations plus a per-cycle comparison with a leading-count reference model.
module tb_normalizador_deslocamento;

  logic        clk;
  logic        reset_n;
  logic        iniciar;
  logic        sinal;
  logic [63:0] entrada;
  logic [63:0] saida;
  logic [5:0]  n;
  logic        zero;
  logic        ocupado;
  logic        pronto;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  normalizador_deslocamento dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Iniciar (iniciar),
    .Sinal   (sinal),
    .Entrada (entrada),
    .Saida   (saida),
    .N       (n),
    .Zero    (zero),
    .Ocupado (ocupado),
    .Pronto  (pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", nome, got, exp, $time);
  endtask

  // Reference: N is the leading-zero count (unsigned) or the number of bits
  // below bit63 that repeat it (signed); steps are N/8 coarse plus N%8 fine.
  function automatic void modelo(input logic [63:0] e, input logic s,
                                 output bit degen, output int cnt);
    degen = (e == 64'd0) || (s && (e == 64'hFFFF_FFFF_FFFF_FFFF));
    cnt = 0;
    if (!degen) begin
      for (int i = 62; i >= 0; i--) begin
        if (!s && e[63] == 1'b1) break;
        if (s) begin
          if (e[i] == e[63]) cnt++;
          else break;
        end else begin
          if (e[63 - cnt] == 1'b0) cnt++;
          else break;
        end
      end
    end
  endfunction

  // Cycle-level expectation derived from the model and the handshake timing.
  bit          m_ocup, m_pronto, m_zero;
  int          m_cnt;
  logic [63:0] m_saida, m_pend_saida;
  logic [5:0]  m_n, m_pend_n;

  always @(posedge clk) begin
    bit dg;
    int c;
    if (!reset_n) begin
      m_ocup <= 0; m_pronto <= 0; m_zero <= 0; m_cnt <= 0;
      m_saida <= 64'd0; m_n <= 6'd0;
    end else if (!m_ocup) begin
      if (iniciar) begin
        modelo(entrada, sinal, dg, c);
        m_ocup <= 1;
        if (dg) begin
          m_saida <= entrada; m_n <= 6'd0; m_zero <= 1; m_pronto <= 1;
        end else begin
          m_zero <= 0;
          m_cnt <= c / 8 + c % 8 + 1;
          m_pend_saida <= entrada << c;
          m_pend_n <= 6'(c);
        end
      end
    end else if (m_pronto) begin
      m_pronto <= 0; m_ocup <= 0;
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_pronto <= 1; m_saida <= m_pend_saida; m_n <= m_pend_n;
      end
    end
  end

  // Per-cycle comparison; results are compared whenever they are defined to be stable.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ocupado", {63'd0, ocupado}, {63'd0, m_ocup});
      check("pronto",  {63'd0, pronto},  {63'd0, m_pronto});
      check("zero",    {63'd0, zero},    {63'd0, m_zero});
      if (!m_ocup || m_pronto) begin
        check("saida", saida, m_saida);
        check("n",     {58'd0, n}, {58'd0, m_n});
      end
    end
  end

  task automatic esperar_pronto(output int m);
    m = 0;
    while (!pronto && m < 100) begin
      @(negedge clk);
      m++;
    end
    if (!pronto) check("timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] e, input logic s, input logic [63:0] xs,
                        input int xn, input logic xz, input int xedge);
    int m;
    @(negedge clk);
    iniciar = 1'b1; entrada = e; sinal = s;
    @(negedge clk);
    iniciar = 1'b0; entrada = {$urandom, $urandom}; sinal = ~s;
    esperar_pronto(m);
    check("latencia", 64'(m), 64'(xedge));
    check("saida_lit", saida, xs);
    check("n_lit", {58'd0, n}, 64'(xn));
    check("zero_lit", {63'd0, zero}, {63'd0, xz});
  endtask

  initial begin
    bit dg;
    int c, m;
    bit viu;
    reset_n = 1'b0; iniciar = 1'b0; sinal = 1'b0; entrada = 64'd0;

    // Pin the reference model on hand-computed cases.
    modelo(64'h0000_0000_0000_0001, 1'b0, dg, c); check("mod_u1", 64'(c), 64'd63);
    modelo(64'h00F0_0000_0000_0000, 1'b0, dg, c); check("mod_uF0", 64'(c), 64'd8);
    modelo(64'hFFFF_FFFF_FFFF_FF00, 1'b1, dg, c); check("mod_s256", 64'(c), 64'd55);
    modelo(64'h4000_0000_0000_0000, 1'b1, dg, c); check("mod_s40", 64'(c), 64'd0);
    modelo(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, dg, c); check("mod_degen", {63'd0, dg}, 64'd1);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("rst_saida", saida, 64'd0);
    check("rst_n", {58'd0, n}, 64'd0);
    check("rst_flags", {61'd0, zero, ocupado, pronto}, 64'd0);
    chk_en = 1;

    run_op(64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 63, 1'b0, 15);
    run_op(64'h00F0_0000_0000_0000, 1'b0, 64'hF000_0000_0000_0000, 8, 1'b0, 2);
    run_op(64'hFFFF_FFFF_FFFF_FF00, 1'b1, 64'h8000_0000_0000_0000, 55, 1'b0, 14);
    run_op(64'h4000_0000_0000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 1'b0, 1);
    run_op(64'h0000_0000_0000_0001, 1'b1, 64'h4000_0000_0000_0000, 62, 1'b0, 14);
    run_op(64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 0, 1'b1, 0);
    run_op(64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 0, 1'b1, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1);

    // Start pulsed mid-operation is ignored; results then hold.
    @(negedge clk);
    iniciar = 1'b1; entrada = 64'h0000_0000_0000_0001; sinal = 1'b0;
    @(negedge clk);
    iniciar = 1'b0;
    repeat (3) @(negedge clk);
    iniciar = 1'b1; entrada = 64'h00F0_0000_0000_0000;
    @(negedge clk);
    iniciar = 1'b0;
    esperar_pronto(m);
    check("ign_n", {58'd0, n}, 64'd63);
    check("ign_saida", saida, 64'h8000_0000_0000_0000);
    repeat (5) @(negedge clk);
    check("hold_n", {58'd0, n}, 64'd63);
    check("hold_saida", saida, 64'h8000_0000_0000_0000);

    // Iniciar held high: back-to-back operations, timing checked by the model.
    iniciar = 1'b1; entrada = 64'h4000_0000_0000_0000; sinal = 1'b1;
    repeat (10) @(negedge clk);
    iniciar = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-NORMALIZA aborts with no Pronto.
    iniciar = 1'b1; entrada = 64'h0000_0000_0000_0001; sinal = 1'b0;
    @(negedge clk);
    iniciar = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_saida", saida, 64'd0);
    check("abort_n", {58'd0, n}, 64'd0);
    check("abort_flags", {61'd0, zero, ocupado, pronto}, 64'd0);
    viu = 0;
    repeat (20) begin
      @(negedge clk);
      if (pronto) viu = 1;
    end
    check("abort_sem_pronto", {63'd0, viu}, 64'd0);
    run_op(64'h00F0_0000_0000_0000, 1'b0, 64'hF000_0000_0000_0000, 8, 1'b0, 2);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
